// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch PC, instruction-memory requester and in-order prefetch queue.
// Optional build macro IFU_PERF_COUNTERS_EN adds fetched/flushed/stall counters.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTRUCTION,
    output logic [63:0] INSTR_PC,
    output logic [63:0] NEXT_PC,
    input  logic        INSTR_READY,
    input  logic        REDIRECT,
    input  logic [63:0] REDIRECT_PC
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_FLUSHED,
    output logic [31:0] PERF_STALL
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [31:0]   word_q [DEPTH];
    logic [63:0]   pc_q   [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, inflight, drop;
    logic [63:0]   fetch_pc, rsp_pc;
    logic          rsp, accept, push, pop, discard;

    // Credit check, handshakes and head-of-queue outputs; redirect blocks requests and pushes.
    always_comb begin
        rsp         = IMEM_RVALID && (inflight != '0);
        IMEM_REQ    = RESET_N && !REDIRECT && (({1'b0, count} + {1'b0, inflight}) < CAP);
        IMEM_ADDR   = fetch_pc;
        accept      = IMEM_REQ && IMEM_READY;
        push        = rsp && !REDIRECT && (drop == '0);
        discard     = rsp && !push;
        INSTR_VALID = count != '0;
        pop         = INSTR_VALID && INSTR_READY && !REDIRECT;
        INSTRUCTION = word_q[head];
        INSTR_PC    = pc_q[head];
        NEXT_PC     = pc_q[head] + 64'd4;
    end

    // Fetch/response PCs, queue pointers and credit counters; drop is rebuilt from inflight on redirect.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp);
            if (REDIRECT) begin
                fetch_pc <= {REDIRECT_PC[63:2], 2'b00};
                rsp_pc   <= {REDIRECT_PC[63:2], 2'b00};
                drop     <= inflight - CW'(rsp);
                head     <= tail;
                count    <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 64'd4;
                if (push) rsp_pc <= rsp_pc + 64'd4;
                if (push) tail <= tail + AW'(1);
                if (pop) head <= head + AW'(1);
                if (discard) drop <= drop - CW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; reset contents define the idle head outputs.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= RESET_PC;
            end
        end else if (push) begin
            word_q[tail] <= IMEM_RDATA;
            pc_q[tail]   <= rsp_pc;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    // Event counters; redirect flushes count both the emptied queue and any same-cycle response.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            PERF_FETCHED <= '0;
            PERF_FLUSHED <= '0;
            PERF_STALL   <= '0;
        end else begin
            PERF_FETCHED <= PERF_FETCHED + 32'(push);
            PERF_FLUSHED <= PERF_FLUSHED + 32'(discard) + (REDIRECT ? 32'(count) : 32'd0);
            PERF_STALL   <= PERF_STALL + 32'(INSTR_READY && !INSTR_VALID);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, stall, redirect, reset and wrap behaviour.
module tb_instr_fetch_unit;
    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IMEM_READY = 1'b1;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        INSTR_READY = 1'b1;
    logic        REDIRECT = 1'b0;
    logic [63:0] REDIRECT_PC = 64'h0;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        INSTR_VALID;
    logic [31:0] INSTRUCTION;
    logic [63:0] INSTR_PC;
    logic [63:0] NEXT_PC;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .IMEM_REQ(IMEM_REQ),
        .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READY(IMEM_READY),
        .IMEM_RVALID(IMEM_RVALID),
        .IMEM_RDATA(IMEM_RDATA),
        .INSTR_VALID(INSTR_VALID),
        .INSTRUCTION(INSTRUCTION),
        .INSTR_PC(INSTR_PC),
        .NEXT_PC(NEXT_PC),
        .INSTR_READY(INSTR_READY),
        .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Instruction memory: word = {16'hC0DE, addr[15:0]}, in-order responses lat edges after accept.
    initial begin
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        forever begin
            @(negedge CLOCK);
            if (!RESET_N) begin
                pend.delete();
                IMEM_RVALID = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                    IMEM_RVALID = 1'b1;
                    IMEM_RDATA  = {16'hC0DE, pend[0].addr[15:0]};
                    void'(pend.pop_front());
                end else begin
                    IMEM_RVALID = 1'b0;
                end
                if (IMEM_REQ && IMEM_READY) pend.push_back('{IMEM_ADDR, cyc + 1 + lat});
            end
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, IMEM_REQ, 64'd0);
        chk({tag, "_addr"}, IMEM_ADDR, 64'h0);
        chk({tag, "_valid"}, INSTR_VALID, 64'd0);
        chk({tag, "_instr"}, INSTRUCTION, 64'h0);
        chk({tag, "_pc"}, INSTR_PC, 64'h0);
        chk({tag, "_npc"}, NEXT_PC, 64'h4);
    endtask

    initial begin
        repeat (3) step();
        chk_reset("rst");
        RESET_N = 1'b1;
        #1;
        chk("c0_req", IMEM_REQ, 64'd1);
        chk("c0_addr", IMEM_ADDR, 64'h0);
        step();
        chk("c1_addr", IMEM_ADDR, 64'h4);
        chk("c1_valid", INSTR_VALID, 64'd0);
        step();
        chk("c2_valid", INSTR_VALID, 64'd1);
        chk("c2_pc", INSTR_PC, 64'h0);
        chk("c2_npc", NEXT_PC, 64'h4);
        chk("c2_instr", INSTRUCTION, 64'hC0DE0000);
        chk("c2_addr", IMEM_ADDR, 64'h8);
        INSTR_READY = 1'b0;
        repeat (10) step();
        chk("stall_req", IMEM_REQ, 64'd0);
        chk("stall_addr", IMEM_ADDR, 64'h10);
        chk("stall_valid", INSTR_VALID, 64'd1);
        chk("stall_pc", INSTR_PC, 64'h0);
        INSTR_READY = 1'b1;
        step();
        chk("drain1_pc", INSTR_PC, 64'h4);
        chk("drain1_npc", NEXT_PC, 64'h8);
        chk("drain1_instr", INSTRUCTION, 64'hC0DE0004);
        step();
        chk("drain2_pc", INSTR_PC, 64'h8);
        step();
        chk("drain3_pc", INSTR_PC, 64'hC);
        chk("drain3_instr", INSTRUCTION, 64'hC0DE000C);

        RESET_N = 1'b0;
        lat = 3;
        step();
        step();
        RESET_N = 1'b1;
        #1;
        chk("l3_c0_req", IMEM_REQ, 64'd1);
        repeat (3) step();
        chk("l3_c3_valid", INSTR_VALID, 64'd0);
        REDIRECT = 1'b1;
        REDIRECT_PC = 64'h103;
        #1;
        chk("redir_req", IMEM_REQ, 64'd0);
        step();
        REDIRECT = 1'b0;
        #1;
        chk("redir_addr", IMEM_ADDR, 64'h100);
        chk("redir_req1", IMEM_REQ, 64'd1);
        chk("redir_valid4", INSTR_VALID, 64'd0);
        repeat (3) step();
        chk("redir_valid7", INSTR_VALID, 64'd0);
        step();
        chk("redir_valid8", INSTR_VALID, 64'd1);
        chk("redir_pc", INSTR_PC, 64'h100);
        chk("redir_npc", NEXT_PC, 64'h104);
        chk("redir_instr", INSTRUCTION, 64'hC0DE0100);
        chk("redir_credit_req", IMEM_REQ, 64'd0);
        step();
        chk("redir_pc2", INSTR_PC, 64'h104);

        RESET_N = 1'b0;
        #1;
        chk_reset("midrst");
        lat = 1;
        step();
        step();
        RESET_N = 1'b1;
        #1;
        chk("restart_req", IMEM_REQ, 64'd1);
        chk("restart_addr", IMEM_ADDR, 64'h0);
        step();
        step();
        chk("restart_valid", INSTR_VALID, 64'd1);
        chk("restart_pc", INSTR_PC, 64'h0);
        REDIRECT = 1'b1;
        REDIRECT_PC = 64'h200;
        step();
        REDIRECT = 1'b0;
        #1;
        chk("coin_valid3", INSTR_VALID, 64'd0);
        chk("coin_addr", IMEM_ADDR, 64'h200);
        chk("coin_req", IMEM_REQ, 64'd1);
        step();
        chk("coin_valid4", INSTR_VALID, 64'd0);
        step();
        chk("coin_pc", INSTR_PC, 64'h200);
        chk("coin_instr", INSTRUCTION, 64'hC0DE0200);
        REDIRECT = 1'b1;
        REDIRECT_PC = 64'h300;
        step();
        REDIRECT_PC = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        chk("b2b_req", IMEM_REQ, 64'd0);
        step();
        REDIRECT = 1'b0;
        #1;
        chk("wrap_addr0", IMEM_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req", IMEM_REQ, 64'd1);
        chk("wrap_valid", INSTR_VALID, 64'd0);
        step();
        chk("wrap_addr1", IMEM_ADDR, 64'h0);
        step();
        chk("wrap_pc", INSTR_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_npc", NEXT_PC, 64'h0);
        chk("wrap_instr", INSTRUCTION, 64'hC0DEFFFC);
        step();
        chk("wrap_pc2", INSTR_PC, 64'h0);
        chk("wrap_npc2", NEXT_PC, 64'h4);
        chk("wrap_instr2", INSTRUCTION, 64'hC0DE0000);
        IMEM_READY = 1'b0;
        step();
        chk("hold_addr1", IMEM_ADDR, 64'h8);
        chk("hold_req", IMEM_REQ, 64'd1);
        chk("hold_pc", INSTR_PC, 64'h4);
        step();
        chk("hold_addr2", IMEM_ADDR, 64'h8);
        chk("hold_valid", INSTR_VALID, 64'd0);
        IMEM_READY = 1'b1;
        step();
        step();
        chk("resume_pc", INSTR_PC, 64'h8);
        chk("resume_instr", INSTRUCTION, 64'hC0DE0008);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the LEGv8 single-cycle core: owns the fetch PC, issues word reads to instruction memory and buffers returned words in a small in-order prefetch queue.
- Presents {INSTRUCTION, INSTR_PC, NEXT_PC} to the control/decode unit with a valid/ready handshake.
- Accepts a redirect (taken B/CBZ target) that flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, prefetch queue entries; also the cap on queue occupancy plus in-flight requests (power of 2, ≥2)
RESET_PC, 64'h0, fetch PC loaded on reset

Ports:
CLOCK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
IMEM_REQ  output  1  read request valid
IMEM_ADDR  output  64  byte address of requested word, bits [1:0] always 0
IMEM_READY  input  1  memory accepts request this cycle
IMEM_RVALID  input  1  one response word valid, in request order
IMEM_RDATA  input  32  response instruction word
INSTR_VALID  output  1  queue head valid
INSTRUCTION  output  32  queue head word
INSTR_PC  output  64  address of queue head word
NEXT_PC  output  64  INSTR_PC + 4, modulo 2^64
INSTR_READY  input  1  decode consumes head this cycle
REDIRECT  input  1  flush and refetch
REDIRECT_PC  input  64  new fetch address; bits [1:0] ignored, treated as 0

Behaviour:
- State: fetch_pc, rsp_pc (64b); queue of DEPTH×{word, pc}; occupancy 0..DEPTH; inflight 0..DEPTH; drop 0..DEPTH.
- Reset (async, RESET_N=0): fetch_pc = rsp_pc = RESET_PC; queue empty; inflight = drop = 0. Outputs: IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_VALID=0, INSTRUCTION=0, INSTR_PC=RESET_PC, NEXT_PC=RESET_PC+4.
- IMEM_REQ = !REDIRECT && (occupancy + inflight < DEPTH). Combinational from registered state and REDIRECT. IMEM_ADDR = fetch_pc (registered).
- Accept = IMEM_REQ && IMEM_READY. On accept: fetch_pc += 4, inflight += 1. IMEM_ADDR holds while REQ is high and not accepted.
- Response (IMEM_RVALID): inflight -= 1.
  - If drop > 0: word discarded, drop -= 1.
  - Else: push {IMEM_RDATA, rsp_pc}, rsp_pc += 4.
  - Minimum response latency is 1 cycle after accept.
  - A response while inflight == 0 is ignored.
- Pop = INSTR_VALID && INSTR_READY, removes head. Push and pop in the same cycle leave occupancy unchanged. INSTR_READY while empty has no effect.
- The credit rule guarantees no push into a full queue, so no overflow path is needed.
- Outputs INSTRUCTION, INSTR_PC and NEXT_PC come from the registered head entry with zero added latency. They are stable while INSTR_VALID && !INSTR_READY.
- REDIRECT has priority over every other event in its cycle:
  - queue emptied; pop ignored;
  - fetch_pc and rsp_pc set to {REDIRECT_PC[63:2], 2'b00};
  - drop set to inflight − IMEM_RVALID, so any same-cycle response is discarded;
  - inflight updated normally;
  - no accept occurs because IMEM_REQ = 0.
  - First post-redirect request issues the next cycle at the new address.
- Back-to-back REDIRECT: the last one wins. Drop accumulates correctly because it is always recomputed from inflight.
- Address arithmetic wraps at 2^64 with no flag.
- Throughput: 1 instruction/cycle sustained when memory latency ≤ DEPTH−1 and decode is always ready.

Optional Feature:
- Macro: IFU_PERF_COUNTERS_EN.
- When defined, adds three outputs, each cleared on reset and wrapping at 2^32:
  - PERF_FETCHED [31:0]: counts pushes.
  - PERF_FLUSHED [31:0]: counts words discarded due to drop plus queue entries emptied by REDIRECT.
  - PERF_STALL [31:0]: counts cycles with INSTR_READY=1 and INSTR_VALID=0.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset release, RESET_PC=0, IMEM_READY=1, latency 1, INSTR_READY=1 → addresses 0, 4, 8… one per cycle; INSTR_VALID from cycle 2; INSTR_PC/NEXT_PC pairs (0,4), (4,8).
- INSTR_READY=0 for 10 cycles → exactly DEPTH=4 words buffered; IMEM_REQ held 0; head remains PC 0. Releasing INSTR_READY drains in order 0, 4, 8, 12.
- Latency 3 with 3 requests in flight, then REDIRECT with REDIRECT_PC=0x103 → queue empty next cycle; 3 stale responses dropped; first delivered INSTR_PC=0x100.
- REDIRECT coincident with IMEM_RVALID and INSTR_READY → response discarded, no pop, drop = inflight−1; no stale word ever reaches INSTR_VALID.
- RESET_N asserted low mid-stream with 2 in flight → all outputs go to reset values immediately; fetch restarts at RESET_PC after release.
- REDIRECT_PC = 0xFFFF_FFFF_FFFF_FFFC → second fetch address wraps to 0; NEXT_PC of the first word = 0.
